// File: rtl/branch_sequencer_if.sv
// Handshake and datapath-strobe bundle between the main control unit and
// branch_sequencer. The statistics counters exist only when
// BRANCH_SEQ_STATS_EN is defined.
interface branch_sequencer_if
`ifdef BRANCH_SEQ_STATS_EN
    #(parameter int CNT_W = 16)
`endif
    ;
    logic       start;
    logic [4:0] ir_op;
    logic       mem_ready;
    logic       con_ff;

    logic       busy;
    logic       done;
    logic       abort;
    logic       taken;

    logic       pc_out;
    logic       mar_in;
    logic       inc_pc;
    logic       z_in;
    logic       zlo_out;
    logic       pc_in;
    logic       mem_read;
    logic       mdr_in;
    logic       mdr_out;
    logic       ir_in;
    logic       gra;
    logic       r_out;
    logic       con_in;
    logic       y_in;
    logic       c_out;
    logic       alu_add;

`ifdef BRANCH_SEQ_STATS_EN
    logic [CNT_W-1:0] taken_cnt;
    logic [CNT_W-1:0] not_taken_cnt;

    modport master (
        output start, ir_op, mem_ready, con_ff,
        input  busy, done, abort, taken,
        input  pc_out, mar_in, inc_pc, z_in, zlo_out, pc_in, mem_read, mdr_in,
        input  mdr_out, ir_in, gra, r_out, con_in, y_in, c_out, alu_add,
        input  taken_cnt, not_taken_cnt
    );

    modport slave (
        input  start, ir_op, mem_ready, con_ff,
        output busy, done, abort, taken,
        output pc_out, mar_in, inc_pc, z_in, zlo_out, pc_in, mem_read, mdr_in,
        output mdr_out, ir_in, gra, r_out, con_in, y_in, c_out, alu_add,
        output taken_cnt, not_taken_cnt
    );
`else
    modport master (
        output start, ir_op, mem_ready, con_ff,
        input  busy, done, abort, taken,
        input  pc_out, mar_in, inc_pc, z_in, zlo_out, pc_in, mem_read, mdr_in,
        input  mdr_out, ir_in, gra, r_out, con_in, y_in, c_out, alu_add
    );

    modport slave (
        input  start, ir_op, mem_ready, con_ff,
        output busy, done, abort, taken,
        output pc_out, mar_in, inc_pc, z_in, zlo_out, pc_in, mem_read, mdr_in,
        output mdr_out, ir_in, gra, r_out, con_in, y_in, c_out, alu_add
    );
`endif
endinterface

// File: rtl/branch_sequencer.sv
// Conditional-branch sequencer (brzr/brnz/brpl/brmi). Fetches the
// instruction, drives Ra onto the bus with con_in so the CON FF evaluates
// the condition, then writes the branch target to PC only when CON is set.
// Optional taken/not-taken statistics: define BRANCH_SEQ_STATS_EN.
//
// state | meaning
// IDLE  | waiting for start
// T0    | PC -> MAR, PC+1 -> Z
// T1    | Z -> PC, memory read into MDR; waits on mem_ready with timeout
// T2    | MDR -> IR
// T3    | Ra -> bus, con_in; non-branch opcode aborts here
// T4    | PC -> Y
// T5    | C (offset) + Y -> Z
// T6    | Z -> PC only if con_ff; result latched into taken
// FIN   | done pulse
module branch_sequencer #(
    parameter logic [4:0] BR_OPCODE    = 5'b10010,
    parameter int          MEM_WAIT_MAX = 8
`ifdef BRANCH_SEQ_STATS_EN
    ,
    parameter int          CNT_W        = 16
`endif
) (
    input  logic                clock,
    input  logic                clear_n,
    branch_sequencer_if.slave   bus
);

    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6, FIN
    } state_t;

    localparam int                WAIT_W    = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout;
    logic              bad_op;
    logic              abort_q;
    logic              taken_q;

    logic busy, done;
    logic pc_out, mar_in, inc_pc, z_in, zlo_out, pc_in, mem_read, mdr_in;
    logic mdr_out, ir_in, gra, r_out, con_in, y_in, c_out, alu_add;

    // The last wait cycle with memory still not ready ends the sequence.
    assign timeout = (state == T1) && !bus.mem_ready && (wait_cnt == WAIT_LAST);
    assign bad_op  = (state == T3) && (bus.ir_op != BR_OPCODE);

    // State register.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state decode; start is only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = T0;
            T0:      state_nxt = T1;
            T1: begin
                if (bus.mem_ready) state_nxt = T2;
                else if (timeout)  state_nxt = IDLE;
            end
            T2:      state_nxt = T3;
            T3:      state_nxt = bad_op ? IDLE : T4;
            T4:      state_nxt = T5;
            T5:      state_nxt = T6;
            T6:      state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore strobe decode; pc_in in T6 follows the live CON flag.
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        pc_out   = 1'b0;
        mar_in   = 1'b0;
        inc_pc   = 1'b0;
        z_in     = 1'b0;
        zlo_out  = 1'b0;
        pc_in    = 1'b0;
        mem_read = 1'b0;
        mdr_in   = 1'b0;
        mdr_out  = 1'b0;
        ir_in    = 1'b0;
        gra      = 1'b0;
        r_out    = 1'b0;
        con_in   = 1'b0;
        y_in     = 1'b0;
        c_out    = 1'b0;
        alu_add  = 1'b0;
        case (state)
            T0: begin
                busy = 1'b1; pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1;
            end
            T1: begin
                busy = 1'b1; zlo_out = 1'b1; pc_in = 1'b1; mem_read = 1'b1; mdr_in = 1'b1;
            end
            T2: begin
                busy = 1'b1; mdr_out = 1'b1; ir_in = 1'b1;
            end
            T3: begin
                busy = 1'b1; gra = 1'b1; r_out = 1'b1; con_in = 1'b1;
            end
            T4: begin
                busy = 1'b1; pc_out = 1'b1; y_in = 1'b1;
            end
            T5: begin
                busy = 1'b1; c_out = 1'b1; alu_add = 1'b1; z_in = 1'b1;
            end
            T6: begin
                busy = 1'b1; zlo_out = 1'b1; pc_in = bus.con_ff;
            end
            FIN: begin
                busy = 1'b1; done = 1'b1;
            end
            default: ;
        endcase
    end

    // Memory wait counter; counts only while stalled in T1, zero elsewhere.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n)
            wait_cnt <= '0;
        else if ((state == T1) && !bus.mem_ready && (wait_cnt != WAIT_LAST))
            wait_cnt <= wait_cnt + WAIT_W'(1);
        else
            wait_cnt <= '0;
    end

    // Abort is registered so it is a clean pulse in the first IDLE cycle.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) abort_q <= 1'b0;
        else          abort_q <= timeout | bad_op;
    end

    // Branch outcome is captured at the end of T6 and held until the next one.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n)          taken_q <= 1'b0;
        else if (state == T6)  taken_q <= bus.con_ff;
    end

`ifdef BRANCH_SEQ_STATS_EN
    logic [CNT_W-1:0] taken_cnt;
    logic [CNT_W-1:0] not_taken_cnt;

    // Saturating outcome counters, updated only by completed branches.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            taken_cnt     <= '0;
            not_taken_cnt <= '0;
        end else if (state == T6) begin
            if (bus.con_ff && !(&taken_cnt))
                taken_cnt <= taken_cnt + CNT_W'(1);
            else if (!bus.con_ff && !(&not_taken_cnt))
                not_taken_cnt <= not_taken_cnt + CNT_W'(1);
        end
    end

    assign bus.taken_cnt     = taken_cnt;
    assign bus.not_taken_cnt = not_taken_cnt;
`endif

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.abort    = abort_q;
    assign bus.taken    = taken_q;
    assign bus.pc_out   = pc_out;
    assign bus.mar_in   = mar_in;
    assign bus.inc_pc   = inc_pc;
    assign bus.z_in     = z_in;
    assign bus.zlo_out  = zlo_out;
    assign bus.pc_in    = pc_in;
    assign bus.mem_read = mem_read;
    assign bus.mdr_in   = mdr_in;
    assign bus.mdr_out  = mdr_out;
    assign bus.ir_in    = ir_in;
    assign bus.gra      = gra;
    assign bus.r_out    = r_out;
    assign bus.con_in   = con_in;
    assign bus.y_in     = y_in;
    assign bus.c_out    = c_out;
    assign bus.alu_add  = alu_add;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer. Strobes are checked as a 16-bit
// vector {pc_out,mar_in,inc_pc,z_in, zlo_out,pc_in,mem_read,mdr_in,
// mdr_out,ir_in,gra,r_out, con_in,y_in,c_out,alu_add}.
module tb_branch_sequencer;

    localparam logic [4:0]  BR_OP  = 5'b10010;
    localparam logic [15:0] S_T0   = 16'hF000;
    localparam logic [15:0] S_T1   = 16'h0F00;
    localparam logic [15:0] S_T2   = 16'h00C0;
    localparam logic [15:0] S_T3   = 16'h0038;
    localparam logic [15:0] S_T4   = 16'h8004;
    localparam logic [15:0] S_T5   = 16'h1003;
    localparam logic [15:0] S_T6NT = 16'h0800;
    localparam logic [15:0] S_T6T  = 16'h0C00;

    logic clock;
    logic clear_n;
    int   n_checks;
    int   n_fail;
    logic taken_model;

`ifdef BRANCH_SEQ_STATS_EN
    branch_sequencer_if #(.CNT_W(4)) bus ();
    branch_sequencer #(.CNT_W(4)) dut (.clock(clock), .clear_n(clear_n), .bus(bus));
`else
    branch_sequencer_if bus ();
    branch_sequencer dut (.clock(clock), .clear_n(clear_n), .bus(bus));
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] strobes();
        return {bus.pc_out, bus.mar_in, bus.inc_pc, bus.z_in,
                bus.zlo_out, bus.pc_in, bus.mem_read, bus.mdr_in,
                bus.mdr_out, bus.ir_in, bus.gra, bus.r_out,
                bus.con_in, bus.y_in, bus.c_out, bus.alu_add};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Entered and left at 1 time unit after a rising edge with the DUT idle.
    task automatic run_seq(input string name, input logic con, input logic [4:0] op, input int waits);
        int cyc;
        cyc = 0;
        bus.start = 1'b1;
        bus.ir_op = op;
        bus.con_ff = con;
        bus.mem_ready = 1'b1;
        check({name, ":idle_busy"}, bus.busy, 1'b0);
        check({name, ":idle_strb"}, strobes(), 16'h0000);
        step(); cyc++;
        bus.start = 1'b0;
        check({name, ":t0_strb"}, strobes(), S_T0);
        check({name, ":t0_busy"}, bus.busy, 1'b1);
        step(); cyc++;
        for (int i = 0; i < 8; i++) begin
            check({name, ":t1_strb"}, strobes(), S_T1);
            bus.mem_ready = (i == waits);
            step(); cyc++;
            if (i == waits) break;
        end
        bus.mem_ready = 1'b0;
        if (waits >= 8) begin
            check({name, ":to_abort"}, bus.abort, 1'b1);
            check({name, ":to_busy"}, bus.busy, 1'b0);
            check({name, ":to_strb"}, strobes(), 16'h0000);
            check({name, ":to_taken"}, bus.taken, taken_model);
            step();
            check({name, ":to_abort_end"}, bus.abort, 1'b0);
            return;
        end
        check({name, ":t2_strb"}, strobes(), S_T2);
        step(); cyc++;
        check({name, ":t3_strb"}, strobes(), S_T3);
        step(); cyc++;
        if (op != BR_OP) begin
            check({name, ":op_abort"}, bus.abort, 1'b1);
            check({name, ":op_busy"}, bus.busy, 1'b0);
            check({name, ":op_strb"}, strobes(), 16'h0000);
            check({name, ":op_taken"}, bus.taken, taken_model);
            step();
            check({name, ":op_abort_end"}, bus.abort, 1'b0);
            check({name, ":op_strb2"}, strobes(), 16'h0000);
            return;
        end
        check({name, ":t4_strb"}, strobes(), S_T4);
        step(); cyc++;
        check({name, ":t5_strb"}, strobes(), S_T5);
        step(); cyc++;
        check({name, ":t6_strb"}, strobes(), con ? S_T6T : S_T6NT);
        step(); cyc++;
        taken_model = con;
        check({name, ":fin_done"}, bus.done, 1'b1);
        check({name, ":fin_busy"}, bus.busy, 1'b1);
        check({name, ":fin_cycle"}, cyc, 8 + waits);
        check({name, ":fin_taken"}, bus.taken, con);
        check({name, ":fin_abort"}, bus.abort, 1'b0);
        step();
        check({name, ":end_done"}, bus.done, 1'b0);
        check({name, ":end_busy"}, bus.busy, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        taken_model = 1'b0;
        clear_n = 1'b0;
        bus.start = 1'b0;
        bus.ir_op = 5'b00000;
        bus.mem_ready = 1'b0;
        bus.con_ff = 1'b0;
        #12;
        check("rst_strb", strobes(), 16'h0000);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_abort", bus.abort, 1'b0);
        check("rst_taken", bus.taken, 1'b0);
        step();
        clear_n = 1'b1;
        step();

        run_seq("taken", 1'b1, BR_OP, 0);
        run_seq("not_taken", 1'b0, BR_OP, 0);
        run_seq("wait3", 1'b1, BR_OP, 3);
        run_seq("timeout", 1'b0, BR_OP, 99);
        run_seq("bad_op", 1'b0, 5'b00011, 0);

        // Reset asserted in the middle of T4.
        bus.start = 1'b1;
        bus.ir_op = BR_OP;
        bus.mem_ready = 1'b1;
        bus.con_ff = 1'b1;
        step();
        bus.start = 1'b0;
        step(); step(); step(); step();
        check("mid_t4_strb", strobes(), S_T4);
        #2;
        clear_n = 1'b0;
        #1;
        check("mid_rst_strb", strobes(), 16'h0000);
        check("mid_rst_busy", bus.busy, 1'b0);
        check("mid_rst_taken", bus.taken, 1'b0);
        taken_model = 1'b0;
        step();
        clear_n = 1'b1;
        bus.mem_ready = 1'b0;
        check("post_rst_strb", strobes(), 16'h0000);
        run_seq("post_rst", 1'b0, BR_OP, 1);

`ifdef BRANCH_SEQ_STATS_EN
        clear_n = 1'b0;
        #1;
        check("stat_rst_t", bus.taken_cnt, 4'h0);
        step();
        clear_n = 1'b1;
        for (int k = 0; k < 20; k++) run_seq("stat", 1'b1, BR_OP, 0);
        check("stat_taken_sat", bus.taken_cnt, 4'hF);
        check("stat_not_taken", bus.not_taken_cnt, 4'h0);
        run_seq("stat_nt", 1'b0, BR_OP, 0);
        check("stat_nt_one", bus.not_taken_cnt, 4'h1);
        run_seq("stat_abort", 1'b0, 5'b00011, 0);
        check("stat_abort_nt", bus.not_taken_cnt, 4'h1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
